mem_port_arbiter: RTL and testbench

// Shares the single unified instruction/data memory of the multicycle ARM core between two requesters:

---
 rtl/mem_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified instruction/data memory between the core controller (port C)
// and the debug/program loader (port D); one outstanding access, registered memory side.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic          c_lock,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_done,
    output logic          c_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_lock,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_err,
    output logic [1:0]    gnt,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          own_d_q, own_d_d;
    logic          prio_d_q, prio_d_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          mem_req_q, mem_req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          c_done_q, c_done_d;
    logic          c_err_q, c_err_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic          d_done_q, d_done_d;
    logic          d_err_q, d_err_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic          pick_d_s;
    logic          own_req_s;
    logic          own_lock_s;
    logic          done_s;
    logic          err_s;
    logic [DW-1:0] rdata_s;

    // Arbitration helpers: prio_d_q set means D was not served last and wins a tie.
    always_comb begin
        pick_d_s   = d_req && (!c_req || ((FIXED_PRIO == 0) && prio_d_q));
        own_req_s  = own_d_q ? d_req  : c_req;
        own_lock_s = own_d_q ? d_lock : c_lock;
    end

    // Next-state and completion logic; completion info is steered to the owner at the end.
    always_comb begin
        state_d   = state_q;
        own_d_d   = own_d_q;
        prio_d_d  = prio_d_q;
        gnt_d     = gnt_q;
        mem_req_d = 1'b0;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        done_s    = 1'b0;
        err_s     = 1'b0;
        rdata_s   = {DW{1'b0}};
        c_done_d  = 1'b0;
        c_err_d   = 1'b0;
        c_rdata_d = {DW{1'b0}};
        d_done_d  = 1'b0;
        d_err_d   = 1'b0;
        d_rdata_d = {DW{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (c_req || d_req) begin
                    own_d_d   = pick_d_s;
                    gnt_d     = pick_d_s ? 2'b10 : 2'b01;
                    we_d      = pick_d_s ? d_we    : c_we;
                    addr_d    = pick_d_s ? d_addr  : c_addr;
                    wdata_d   = pick_d_s ? d_wdata : c_wdata;
                    mem_req_d = 1'b1;
                    cnt_d     = {CW{1'b0}};
                    state_d   = ST_ACCESS;
                end else begin
                    gnt_d = 2'b00;
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    done_s  = 1'b1;
                    rdata_s = we_q ? {DW{1'b0}} : mem_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    mem_req_d = 1'b1;
                    cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                prio_d_d = !own_d_q;
                if (own_lock_s && own_req_s) begin
                    // Locked owner chains straight into its next access; the other port waits.
                    we_d      = own_d_q ? d_we    : c_we;
                    addr_d    = own_d_q ? d_addr  : c_addr;
                    wdata_d   = own_d_q ? d_wdata : c_wdata;
                    mem_req_d = 1'b1;
                    cnt_d     = {CW{1'b0}};
                    state_d   = ST_ACCESS;
                end else begin
                    gnt_d   = 2'b00;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase

        if (own_d_q) begin
            d_done_d  = done_s;
            d_err_d   = err_s;
            d_rdata_d = rdata_s;
        end else begin
            c_done_d  = done_s;
            c_err_d   = err_s;
            c_rdata_d = rdata_s;
        end
    end

    // State and output registers; async reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            own_d_q   <= 1'b0;
            prio_d_q  <= 1'b0;
            gnt_q     <= 2'b00;
            mem_req_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= {AW{1'b0}};
            wdata_q   <= {DW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            c_done_q  <= 1'b0;
            c_err_q   <= 1'b0;
            c_rdata_q <= {DW{1'b0}};
            d_done_q  <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= {DW{1'b0}};
        end else begin
            state_q   <= state_d;
            own_d_q   <= own_d_d;
            prio_d_q  <= prio_d_d;
            gnt_q     <= gnt_d;
            mem_req_q <= mem_req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            c_done_q  <= c_done_d;
            c_err_q   <= c_err_d;
            c_rdata_q <= c_rdata_d;
            d_done_q  <= d_done_d;
            d_err_q   <= d_err_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign c_done    = c_done_q;
    assign c_err     = c_err_q;
    assign c_rdata   = c_rdata_q;
    assign d_done    = d_done_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin and a fixed-priority instance share
// requester stimulus; each has its own latency-programmable memory responder.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0, c_lock = 1'b0;
    logic [31:0] c_addr = 32'h0, c_wdata = 32'h0;
    logic        d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
    logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;

    logic [31:0] rr_c_rdata, rr_d_rdata, rr_mem_addr, rr_mem_wdata, rr_mem_rdata;
    logic        rr_c_done, rr_c_err, rr_d_done, rr_d_err, rr_mem_req, rr_mem_we, rr_mem_ready;
    logic [1:0]  rr_gnt;
    logic [31:0] fp_c_rdata, fp_d_rdata, fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
    logic        fp_c_done, fp_c_err, fp_d_done, fp_d_err, fp_mem_req, fp_mem_we, fp_mem_ready;
    logic [1:0]  fp_gnt;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 2;
    logic resp_en = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(0), .TIMEOUT(16)) dut_rr (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(rr_c_rdata), .c_done(rr_c_done), .c_err(rr_c_err),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(rr_d_rdata), .d_done(rr_d_done), .d_err(rr_d_err),
        .gnt(rr_gnt), .mem_req(rr_mem_req), .mem_we(rr_mem_we), .mem_addr(rr_mem_addr),
        .mem_wdata(rr_mem_wdata), .mem_ready(rr_mem_ready), .mem_rdata(rr_mem_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(1), .TIMEOUT(16)) dut_fp (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(fp_c_rdata), .c_done(fp_c_done), .c_err(fp_c_err),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(fp_d_rdata), .d_done(fp_d_done), .d_err(fp_d_err),
        .gnt(fp_gnt), .mem_req(fp_mem_req), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr),
        .mem_wdata(fp_mem_wdata), .mem_ready(fp_mem_ready), .mem_rdata(fp_mem_rdata)
    );

    function automatic logic [31:0] mem_rd_f(input logic [31:0] a);
        return a ^ 32'hE04F002F;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rr_c_done(input int max, output int n);
        n = 0;
        while (!rr_c_done && n < max) begin
            @(negedge clk);
            n++;
        end
        check_eq("c_done_seen", {63'd0, rr_c_done}, 64'd1);
    endtask

    // Memory responders: ready after lat cycles of mem_req, one-cycle pulse.
    int rr_wait = 0, fp_wait = 0;
    always @(negedge clk) begin
        if (!reset) begin
            rr_mem_ready <= 1'b0; rr_wait <= 0;
        end else if (rr_mem_ready) begin
            rr_mem_ready <= 1'b0; rr_wait <= 0;
        end else if (rr_mem_req && resp_en) begin
            if (rr_wait >= lat - 1) begin
                rr_mem_ready <= 1'b1;
                rr_mem_rdata <= mem_rd_f(rr_mem_addr);
            end else begin
                rr_wait <= rr_wait + 1;
            end
        end else begin
            rr_wait <= 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            fp_mem_ready <= 1'b0; fp_wait <= 0;
        end else if (fp_mem_ready) begin
            fp_mem_ready <= 1'b0; fp_wait <= 0;
        end else if (fp_mem_req && resp_en) begin
            if (fp_wait >= lat - 1) begin
                fp_mem_ready <= 1'b1;
                fp_mem_rdata <= mem_rd_f(fp_mem_addr);
            end else begin
                fp_wait <= fp_wait + 1;
            end
        end else begin
            fp_wait <= 0;
        end
    end

    // Grant log: owner recorded at every rising edge of mem_req.
    logic [1:0] rr_q[$];
    logic [1:0] fp_q[$];
    logic rr_prev = 1'b0, fp_prev = 1'b0;
    always @(negedge clk) begin
        if (rr_mem_req && !rr_prev) rr_q.push_back(rr_gnt);
        if (fp_mem_req && !fp_prev) fp_q.push_back(fp_gnt);
        rr_prev <= rr_mem_req;
        fp_prev <= fp_mem_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nd, gap, last, rb, fb;
        logic seen;
        logic [31:0] rd;

        rr_mem_rdata = 32'h0;
        fp_mem_rdata = 32'h0;
        rr_mem_ready = 1'b0;
        fp_mem_ready = 1'b0;

        // Reset state
        cyc(3);
        check_eq("rst_gnt", {62'd0, rr_gnt}, 64'd0);
        check_eq("rst_mem_req", {63'd0, rr_mem_req}, 64'd0);
        check_eq("rst_done", {62'd0, rr_c_done, rr_d_done}, 64'd0);
        reset = 1'b1;
        cyc(2);

        // 1: C read alone
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20;
        cyc(1);
        check_eq("t1_mem_req", {63'd0, rr_mem_req}, 64'd1);
        check_eq("t1_mem_addr", {32'd0, rr_mem_addr}, 64'h20);
        check_eq("t1_gnt", {62'd0, rr_gnt}, 64'd1);
        wait_rr_c_done(20, n);
        check_eq("t1_latency", n, 64'd2);
        check_eq("t1_c_rdata", {32'd0, rr_c_rdata}, 64'hE04F000F);
        check_eq("t1_c_err", {63'd0, rr_c_err}, 64'd0);
        check_eq("t1_d_done", {63'd0, rr_d_done}, 64'd0);
        c_req = 1'b0;
        cyc(1);
        check_eq("t1_done_pulse", {63'd0, rr_c_done}, 64'd0);
        check_eq("t1_rdata_clr", {32'd0, rr_c_rdata}, 64'd0);
        check_eq("t1_gnt_idle", {62'd0, rr_gnt}, 64'd0);

        // 2: simultaneous requests, RR alternates, fixed priority keeps C
        reset = 1'b0; cyc(2); reset = 1'b1;
        rb = rr_q.size(); fb = fp_q.size();
        c_req = 1'b1; c_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        for (int k = 0; k < 60 && !((rr_q.size() - rb >= 4) && (fp_q.size() - fb >= 4)); k++)
            cyc(1);
        c_req = 1'b0; d_req = 1'b0;
        cyc(12);
        check_eq("t2_rr_count", (rr_q.size() - rb >= 4), 64'd1);
        check_eq("t2_fp_count", (fp_q.size() - fb >= 4), 64'd1);
        if (rr_q.size() - rb >= 4 && fp_q.size() - fb >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq("t2_rr_gnt", {62'd0, rr_q[rb + i]}, (i % 2 == 0) ? 64'd1 : 64'd2);
                check_eq("t2_fp_gnt", {62'd0, fp_q[fb + i]}, 64'd1);
            end
        end

        // 3: locked D writes starve C until lock drops
        rb = rr_q.size();
        d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        nd = 0; gap = 0; last = 0; seen = 1'b0;
        for (int k = 0; k < 60 && nd < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                c_req = 1'b1; c_we = 1'b0; c_addr = 32'h200;
            end
            if (rr_mem_req && rr_gnt == 2'b10 && !seen) begin
                seen = 1'b1;
                check_eq("t3_mem_we", {63'd0, rr_mem_we}, 64'd1);
                check_eq("t3_mem_addr", {32'd0, rr_mem_addr}, 64'h100);
                check_eq("t3_mem_wdata", {32'd0, rr_mem_wdata}, 64'hDEADBEEF);
            end
            if (rr_d_done) begin
                nd++;
                if (nd == 1) check_eq("t3_wr_rdata", {32'd0, rr_d_rdata}, 64'd0);
                if (nd == 2) gap = k - last;
                last = k;
                if (nd == 3) begin
                    d_req = 1'b0; d_lock = 1'b0; d_we = 1'b0;
                end
            end
        end
        check_eq("t3_d_accesses", nd, 64'd3);
        check_eq("t3_lock_gap", gap, 64'd3);
        wait_rr_c_done(20, n);
        check_eq("t3_c_rdata", {32'd0, rr_c_rdata}, 64'hE04F022F);
        c_req = 1'b0;
        cyc(3);
        check_eq("t3_q_count", (rr_q.size() - rb >= 4), 64'd1);
        if (rr_q.size() - rb >= 4) begin
            for (int i = 0; i < 4; i++)
                check_eq("t3_gnt_seq", {62'd0, rr_q[rb + i]}, (i < 3) ? 64'd2 : 64'd1);
        end

        // 4: timeout with no mem_ready
        resp_en = 1'b0;
        c_req = 1'b1; c_addr = 32'h300;
        cyc(1);
        check_eq("t4_mem_req", {63'd0, rr_mem_req}, 64'd1);
        wait_rr_c_done(40, n);
        check_eq("t4_timeout_cycles", n, 64'd16);
        check_eq("t4_c_err", {63'd0, rr_c_err}, 64'd1);
        check_eq("t4_c_rdata", {32'd0, rr_c_rdata}, 64'd0);
        c_req = 1'b0;
        cyc(1);
        check_eq("t4_idle_gnt", {62'd0, rr_gnt}, 64'd0);
        check_eq("t4_err_pulse", {63'd0, rr_c_err}, 64'd0);

        // 5: reset during ACCESS, then C wins tie
        c_req = 1'b1; d_req = 1'b1; c_addr = 32'h40; d_addr = 32'h80;
        cyc(3);
        check_eq("t5_in_access", {63'd0, rr_mem_req}, 64'd1);
        reset = 1'b0;
        #1;
        check_eq("t5_mem_req", {63'd0, rr_mem_req}, 64'd0);
        check_eq("t5_gnt", {62'd0, rr_gnt}, 64'd0);
        check_eq("t5_done_err", {60'd0, rr_c_done, rr_c_err, rr_d_done, rr_d_err}, 64'd0);
        cyc(2);
        resp_en = 1'b1;
        reset = 1'b1;
        cyc(1);
        check_eq("t5_rr_tie_c", {62'd0, rr_gnt}, 64'd1);
        check_eq("t5_fp_tie_c", {62'd0, fp_gnt}, 64'd1);
        c_req = 1'b0; d_req = 1'b0;
        cyc(15);

        // 6: c_req dropped mid-access
        lat = 4;
        rb = rr_q.size();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h44;
        cyc(1);
        check_eq("t6_mem_req", {63'd0, rr_mem_req}, 64'd1);
        c_req = 1'b0;
        nd = 0; rd = 32'h0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (rr_c_done) begin
                nd++;
                rd = rr_c_rdata;
            end
        end
        check_eq("t6_done_count", nd, 64'd1);
        check_eq("t6_c_rdata", {32'd0, rd}, 64'hE04F006B);
        check_eq("t6_mem_req_count", rr_q.size() - rb, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
